wb_fifo_slave: RTL

//  Wishbone B4 classic slave placed directly downstream of wb_intercon on one i2s_stb_o lane.

---
 rtl/wb_fifo_slave_if.sv | 17 +
 rtl/wb_fifo_slave.sv | 101 ++++++++++
 2 files changed

// File: rtl/wb_fifo_slave_if.sv
// wb_fifo_slave_if: Wishbone B4 classic bus bundle between the intercon lane and the FIFO slave.
interface wb_fifo_slave_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat_w;
    logic [7:0]            sel;
    logic                  ack;
    logic                  err;
    logic [DATA_WIDTH-1:0] dat_r;
    modport master(output cyc, stb, we, adr, dat_w, sel, input ack, err, dat_r);
    modport slave(input cyc, stb, we, adr, dat_w, sel, output ack, err, dat_r);
endinterface

// File: rtl/wb_fifo_slave.sv
// wb_fifo_slave: Wishbone slave exposing a FIFO through DATA/STATUS/CTRL/THRESH with a level irq.
// Define WB_FIFO_SLAVE_PEEK_EN to add the read-only PEEK register at offset 0x10.
module wb_fifo_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    wb_fifo_slave_if.slave wb,
    output logic           irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic {IDLE, RESP} state_t;
    state_t state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0] th_q, th_d, th_eff;
    logic [DATA_WIDTH-1:0] dat_q, dat_d, rdat;
    logic en_q, en_d, ack_q, ack_d, err_q, err_d, irq_q, irq_d;
    logic req, ok, wr_ok, push, pop, flush, full, empty, sel_ok, peek;
    logic is_data, is_stat, is_ctrl, is_th;
    logic [ADDR_WIDTH-3:0] wa;
    logic unused;
    assign wa      = wb.adr[ADDR_WIDTH-1:2];
    assign is_data = wa == (ADDR_WIDTH-2)'(0);
    assign is_stat = wa == (ADDR_WIDTH-2)'(1);
    assign is_ctrl = wa == (ADDR_WIDTH-2)'(2);
    assign is_th   = wa == (ADDR_WIDTH-2)'(3);
`ifdef WB_FIFO_SLAVE_PEEK_EN
    assign peek    = wa == (ADDR_WIDTH-2)'(4);
`else
    assign peek    = 1'b0;
`endif
    assign unused  = ^{wb.sel[7:4], wb.adr[1:0]};
    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign sel_ok  = wb.sel[3:0] == 4'hf;
    assign req     = wb.cyc & wb.stb & (state_q == IDLE);
    always_comb begin
        state_d = IDLE;
        if (req) state_d = RESP;
        ok = is_data ? (wb.we ? sel_ok & ~full : ~empty)
           : is_stat ? ~wb.we
           : (is_ctrl | is_th) ? (~wb.we | sel_ok)
           : peek & ~wb.we & ~empty;
        rdat = (is_data | peek) ? mem_q[rp_q]
             : is_stat ? {16'h0, 8'(cnt_q), 5'h0, irq_q, full, empty}
             : is_ctrl ? {31'h0, en_q}
             : {24'h0, th_q};
        wr_ok  = req & ok & wb.we;
        push   = wr_ok & is_data;
        pop    = req & ok & ~wb.we & is_data;
        flush  = wr_ok & is_ctrl & wb.dat_w[1];
        wp_d   = flush ? '0 : wp_q + AW'(push);
        rp_d   = flush ? '0 : rp_q + AW'(pop);
        cnt_d  = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
        en_d   = (wr_ok & is_ctrl) ? wb.dat_w[0] : en_q;
        th_d   = (wr_ok & is_th) ? wb.dat_w[7:0] : th_q;
        ack_d  = req & ok;
        err_d  = req & ~ok;
        dat_d  = (req & ok & ~wb.we) ? rdat : '0;
        // threshold 0 behaves as 1 so an enabled irq never fires on an empty FIFO
        th_eff = (th_q == 8'h0) ? 8'h1 : th_q;
        irq_d  = en_q & (9'(cnt_q) >= {1'b0, th_eff});
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            th_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            th_q    <= th_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            irq_q   <= irq_d;
            dat_q   <= dat_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wp_q] <= wb.dat_w;
    end
    assign wb.ack   = ack_q & wb.cyc & (state_q == RESP);
    assign wb.err   = err_q & wb.cyc & (state_q == RESP);
    assign wb.dat_r = dat_q;
    assign irq_o    = irq_q;
endmodule
